// File: rtl/panda_pipe_adder.sv
// Ripple-chunk pipelined adder/subtractor: one ChunkW slice per stage, with the
// operand bits carried forward and the result re-aligned at the output, under a global stall.
module panda_pipe_adder #(
  parameter int Width  = 32,
  parameter int Stages = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] operand_a_i,
  input  logic [Width-1:0] operand_b_i,
  input  logic             subtract_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] result_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int ChunkW = Width / Stages;

  logic [Width-1:0] r_a   [Stages];
  logic [Width-1:0] r_b   [Stages];
  logic [Width-1:0] r_sum [Stages];
  logic             r_c   [Stages];
  logic             r_v   [Stages];
  logic             r_ovf;
  logic             r_zero;

  logic [Width-1:0] w_aIn     [Stages];
  logic [Width-1:0] w_bIn     [Stages];
  logic [Width-1:0] w_sumIn   [Stages];
  logic [Width-1:0] w_sumNext [Stages];
  logic             w_cIn     [Stages];
  logic             w_vIn     [Stages];
  logic [ChunkW:0]  w_chunk   [Stages];
  logic             w_en;
  logic             w_ovfNext;
  logic             w_zeroNext;

  assign w_en        = !r_v[Stages-1] || out_ready_i;
  assign in_ready_o  = w_en;
  assign out_valid_o = r_v[Stages-1];
  assign result_o    = r_sum[Stages-1];
  assign carry_o     = r_c[Stages-1];
  assign overflow_o  = r_ovf;
  assign zero_o      = r_zero;

  // Stage 0 takes the raw operands (b pre-inverted for subtract, subtract as carry-in);
  // each later stage works on the previous stage's registers, one chunk per stage.
  always_comb begin
    w_aIn[0]   = operand_a_i;
    w_bIn[0]   = operand_b_i ^ {Width{subtract_i}};
    w_sumIn[0] = '0;
    w_cIn[0]   = subtract_i;
    w_vIn[0]   = in_valid_i;
    for (int k = 1; k < Stages; k++) begin
      w_aIn[k]   = r_a[k-1];
      w_bIn[k]   = r_b[k-1];
      w_sumIn[k] = r_sum[k-1];
      w_cIn[k]   = r_c[k-1];
      w_vIn[k]   = r_v[k-1];
    end
    for (int k = 0; k < Stages; k++) begin
      w_chunk[k] = {1'b0, w_aIn[k][k*ChunkW +: ChunkW]}
                 + {1'b0, w_bIn[k][k*ChunkW +: ChunkW]}
                 + {{ChunkW{1'b0}}, w_cIn[k]};
      w_sumNext[k] = w_sumIn[k];
      w_sumNext[k][k*ChunkW +: ChunkW] = w_chunk[k][ChunkW-1:0];
    end
    w_ovfNext  = (w_aIn[Stages-1][Width-1] == w_bIn[Stages-1][Width-1]) &&
                 (w_sumNext[Stages-1][Width-1] != w_aIn[Stages-1][Width-1]);
    w_zeroNext = (w_sumNext[Stages-1] == '0);
  end

  // Flush only kills valid bits; data may keep stale values since nothing reads it unflagged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < Stages; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
        r_c[k]   <= 1'b0;
        r_v[k]   <= 1'b0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_en) begin
      for (int k = 0; k < Stages; k++) begin
        r_a[k]   <= w_aIn[k];
        r_b[k]   <= w_bIn[k];
        r_sum[k] <= w_sumNext[k];
        r_c[k]   <= w_chunk[k][ChunkW];
        r_v[k]   <= w_vIn[k] && !flush_i;
      end
      r_ovf  <= w_ovfNext;
      r_zero <= w_zeroNext;
    end else if (flush_i) begin
      for (int k = 0; k < Stages; k++) begin
        r_v[k] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_panda_pipe_adder.sv
// Directed bench for panda_pipe_adder (Width=32, Stages=4): latency, flags,
// back-pressure, flush and reset, all driven and sampled on the falling edge.
module tb_panda_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        sub;
  logic        outValid;
  logic        outReady;
  logic [31:0] result;
  logic        carry;
  logic        overflow;
  logic        zero;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  panda_pipe_adder #(.Width(32), .Stages(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (inValid),
    .in_ready_o  (inReady),
    .operand_a_i (opA),
    .operand_b_i (opB),
    .subtract_i  (sub),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .result_o    (result),
    .carry_o     (carry),
    .overflow_o  (overflow),
    .zero_o      (zero)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkResult(input string tag, input logic [31:0] r, input logic c, input logic o, input logic z);
    checkOutput({tag, ".valid"}, {63'd0, outValid}, 64'd1);
    checkOutput({tag, ".result"}, {32'd0, result}, {32'd0, r});
    checkOutput({tag, ".carry"}, {63'd0, carry}, {63'd0, c});
    checkOutput({tag, ".overflow"}, {63'd0, overflow}, {63'd0, o});
    checkOutput({tag, ".zero"}, {63'd0, zero}, {63'd0, z});
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s);
    inValid = 1'b1;
    opA     = a;
    opB     = b;
    sub     = s;
  endtask

  // Issue one op, confirm nothing emerges for 3 edges, then the result on the 4th, then gone.
  task automatic runSingle(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s,
                           input logic [31:0] r, input logic c, input logic o, input logic z);
    applyStimulus(a, b, s);
    @(negedge clk);
    inValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput({tag, ".early"}, {63'd0, outValid}, 64'd0);
      @(negedge clk);
    end
    checkResult(tag, r, c, o, z);
    @(negedge clk);
    checkOutput({tag, ".drained"}, {63'd0, outValid}, 64'd0);
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    outReady = 1'b1;
    applyStimulus(32'h1111_1111, 32'h2222_2222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset.ready", {63'd0, inReady}, 64'd1);
    checkOutput("reset.valid", {63'd0, outValid}, 64'd0);
    checkOutput("reset.result", {32'd0, result}, 64'd0);
    checkOutput("reset.flags", {61'd0, carry, overflow, zero}, 64'd0);
    rst     = 1'b0;
    inValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("reset.noCapture", {63'd0, outValid}, 64'd0);
    end

    runSingle("addOvf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    runSingle("addWrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    runSingle("subBorrow",32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    runSingle("subEqual", 32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    runSingle("subOvf",   32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    runSingle("addPlain", 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 32'h2143_6587, 1'b0, 1'b0, 1'b0);
    runSingle("addChunk", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);

    // Back-pressure: four back-to-back ops, consumer stalled when the first arrives.
    outReady = 1'b0;
    applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0);
    @(negedge clk);
    applyStimulus(32'h0000_000A, 32'h0000_0014, 1'b0);
    @(negedge clk);
    applyStimulus(32'h0000_0100, 32'h0000_0001, 1'b1);
    @(negedge clk);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("stall.ready", {63'd0, inReady}, 64'd0);
    checkResult("stall.first", 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall.holdReady", {63'd0, inReady}, 64'd0);
      checkResult("stall.hold", 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    end
    outReady = 1'b1;
    @(negedge clk);
    checkResult("stall.second", 32'h0000_001E, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkResult("stall.third", 32'h0000_00FF, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkResult("stall.fourth", 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("stall.drained", {63'd0, outValid}, 64'd0);

    // Flush with three ops in flight, plus one presented in the flush cycle.
    applyStimulus(32'h0000_0011, 32'h0000_0001, 1'b0);
    @(negedge clk);
    applyStimulus(32'h0000_0022, 32'h0000_0001, 1'b0);
    @(negedge clk);
    applyStimulus(32'h0000_0033, 32'h0000_0001, 1'b0);
    @(negedge clk);
    applyStimulus(32'h0000_0044, 32'h0000_0001, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b0);
    checkOutput("flush.killed", {63'd0, outValid}, 64'd0);
    @(negedge clk);
    inValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("flush.quiet", {63'd0, outValid}, 64'd0);
      @(negedge clk);
    end
    checkResult("flush.next", 32'h0000_000C, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("flush.drained", {63'd0, outValid}, 64'd0);

    // Reset with ops in flight: outputs clear and nothing stale emerges.
    applyStimulus(32'h0000_1000, 32'h0000_0234, 1'b0);
    @(negedge clk);
    applyStimulus(32'h0000_2000, 32'h0000_0345, 1'b0);
    @(negedge clk);
    inValid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    checkOutput("midReset.valid", {63'd0, outValid}, 64'd0);
    checkOutput("midReset.ready", {63'd0, inReady}, 64'd1);
    checkOutput("midReset.result", {32'd0, result}, 64'd0);
    checkOutput("midReset.flags", {61'd0, carry, overflow, zero}, 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("midReset.noStale", {63'd0, outValid}, 64'd0);
    end
    runSingle("afterReset", 32'h0000_0040, 32'h0000_0002, 1'b1, 32'h0000_003E, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/panda_pipe_adder.md
PANDA_PIPE_ADDER -- requirements
Module: panda_pipe_adder

Interface
REQ-001 The block SHALL have parameter Width, default 32, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter Stages, default 4, meaning pipeline depth; legal values are 1..Width with Width % Stages == 0; chunk width ChunkW = Width/Stages.
REQ-003 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 flush_i  input  1  synchronous kill of all in-flight operations.
REQ-006 in_valid_i  input  1  operands and mode are valid this cycle.
REQ-007 in_ready_o  output  1  block accepts the operation this cycle.
REQ-008 operand_a_i  input  Width  first operand.
REQ-009 operand_b_i  input  Width  second operand.
REQ-010 subtract_i  input  1  0 computes a+b; 1 computes a-b.
REQ-011 out_valid_o  output  1  result and flags are valid.
REQ-012 out_ready_i  input  1  consumer accepts the result this cycle.
REQ-013 result_o  output  Width  sum or difference, modulo 2^Width.
REQ-014 carry_o  output  1  carry out of bit Width-1; for subtract, 1 means no borrow.
REQ-015 overflow_o  output  1  signed two's-complement overflow.
REQ-016 zero_o  output  1  result_o == 0.

Function
REQ-017 Subtraction SHALL be computed as a + ~b + 1, with subtract_i injected as the carry-in of chunk 0.
REQ-018 Stage k (0..Stages-1) SHALL add chunk k of a and of (b XOR subtract) plus the registered carry from stage k-1, producing a ChunkW result slice and carry; carry-lookahead across chunks is not permitted.
REQ-019 Operand chunks not yet consumed SHALL be carried forward in skew registers; completed result chunks SHALL be carried forward so that all Width bits emerge aligned.
REQ-020 Latency SHALL be exactly Stages cycles from the accepting edge (in_valid_i & in_ready_o) to out_valid_o high, absent stalls; Stages=1 gives one-cycle latency.
REQ-021 Throughput SHALL be one operation per cycle when out_ready_i is held high.
REQ-022 Pipeline advance enable SHALL be en = !out_valid_o | out_ready_i; in_ready_o SHALL equal en, combinationally.
REQ-023 When en is 0, all stage registers, valid bits, result_o and flags SHALL hold their values.
REQ-024 A per-stage valid bit SHALL accompany each stage; bubbles propagate as invalid stages and do not block upstream stages only when en is 1 (global stall, no bubble collapsing).
REQ-025 overflow_o SHALL be a[W-1] == b'[W-1] && result[W-1] != a[W-1], where b' is the (possibly inverted) b, all taken from the final stage.
REQ-026 carry_o, overflow_o and zero_o SHALL be registered alongside result_o, valid in the same cycle as out_valid_o.
REQ-027 out_valid_o SHALL remain high with stable data until the cycle out_ready_i is high.
REQ-028 flush_i high at an edge SHALL clear every valid bit including out_valid_o; data registers may retain values; an operation presented with in_valid_i in the same cycle as flush_i SHALL be discarded.
REQ-029 Operations SHALL complete in acceptance order; none shall be duplicated or dropped except by flush_i or rst_i.

Reset
REQ-030 rst_i high at an edge SHALL clear all valid bits, stage data, skew registers, result_o, carry_o, overflow_o and zero_o to 0; rst_i takes priority over flush_i and handshakes.
REQ-031 While rst_i is high, in_ready_o SHALL be 1 (out_valid_o is 0) and no input shall be captured; the first operation is accepted on the first edge with rst_i low.
REQ-032 Reset mid-operation SHALL discard all in-flight operations; no stale result shall appear afterwards.

Verification (Width=32, Stages=4, out_ready_i=1 unless stated)
REQ-033 add 0x7FFFFFFF + 0x00000001 -> 4 cycles later result 0x80000000, carry 0, overflow 1, zero 0.
REQ-034 add 0xFFFFFFFF + 0x00000001 -> result 0x00000000, carry 1, overflow 0, zero 1 (carry through all chunks).
REQ-035 sub 0x00000000 - 0x00000001 -> result 0xFFFFFFFF, carry 0, overflow 0, zero 0; sub 5 - 5 -> result 0, carry 1, zero 1.
REQ-036 Four back-to-back ops, out_ready_i low when first result appears -> in_ready_o low, outputs held 3 cycles; release -> results in order, one per cycle.
REQ-037 flush_i pulsed with 3 ops in flight -> no out_valid_o for those ops; op issued next cycle emerges after 4 cycles.
REQ-038 rst_i asserted with ops in flight -> all outputs 0 next cycle; no result emerges after rst_i drops.
